// File: rtl/uart_transmitter.sv
// 8N1 UART transmit path: a small byte FIFO fed by a write strobe, drained by a
// start/data/stop shifter that emits frames back-to-back while bytes remain queued.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_full,
    output logic       o_tx_data,
    output logic       o_busy,
    output logic       o_done
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [BAUD_W-1:0]  baud;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               baud_done;

    assign o_full     = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign push       = i_wr && !o_full;
    assign baud_done  = (baud == BAUD_LAST);
    // The shifter takes a byte from idle, or straight out of a finishing stop bit.
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));
    assign o_busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            o_tx_data <= 1'b1;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_tx_data <= 1'b1;
                    if (pop) begin
                        shift     <= mem[rd_ptr];
                        baud      <= '0;
                        o_tx_data <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud      <= '0;
                        o_tx_data <= shift[0];
                        bit_idx   <= '0;
                        state     <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx != 3'd7) begin
                            shift     <= {1'b0, shift[7:1]};
                            o_tx_data <= shift[1];
                            bit_idx   <= bit_idx + 1'b1;
                        end else begin
                            o_tx_data <= 1'b1;
                            state     <= STOP;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud   <= '0;
                        o_done <= 1'b1;
                        if (pop) begin
                            shift     <= mem[rd_ptr];
                            o_tx_data <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit half of the UART: accepts bytes from the core over a write strobe, buffers them in a small FIFO, and shifts each one out on the TX line as an 8N1 frame. Frame format is one start bit (0), eight data bits LSB first, and one stop bit (1). Bit period is a fixed number of system clocks; the default is 9600 baud from a 100 MHz clock. It pairs with `receiver`, and a loopback of `o_tx_data` into `receiver.i_rx_data` must reproduce every byte.

## Interface
- `CLKS_PER_BIT`, default 10416: clocks per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte entries in the TX FIFO; must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_wr`  in  1  write strobe; enqueues `i_data` on a rising edge when `o_full`=0.
- `i_data`  in  8  byte to transmit.
- `o_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `o_tx_data`  out  1  serial line; idles high; registered.
- `o_busy`  out  1  FSM not in IDLE (frame in progress).
- `o_done`  out  1  one-cycle pulse after a stop bit completes.

## Operation
- Reset (async, while `i_rst_n`=0) drives:
  - `o_tx_data`=1, `o_busy`=0, `o_full`=0, `o_done`=0.
  - FIFO is flushed (pointers and count = 0); FSM goes to IDLE; baud counter and bit index are cleared.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count register of width $clog2(FIFO_DEPTH)+1.
  - `o_full` = (count == FIFO_DEPTH), derived from registered count.
  - A write with `o_full`=1 is dropped silently, even if a pop occurs on the same edge.
  - A push and a pop on the same edge leave count unchanged.
- FSM has four states: IDLE, START, DATA, STOP.
- IDLE:
  - `o_tx_data`=1.
  - If FIFO non-empty at an edge: pop the head into the shift register, clear the baud counter, set `o_tx_data`=0, go to START.
- Baud counter runs 0..CLKS_PER_BIT-1 in START, DATA and STOP. Each bit holds for exactly CLKS_PER_BIT cycles. Terminal count advances to the next bit.
- START, at terminal count:
  - Drive shift[0], go to DATA with bit index 0.
- DATA, at each terminal count:
  - If index < 7: shift right, drive the new bit 0, increment index.
  - At index 7: drive 1, go to STOP.
- STOP, at terminal count:
  - Assert `o_done` for the following cycle.
  - If FIFO non-empty, pop and go directly to START with `o_tx_data`=0, so frames are back-to-back with no idle gap.
  - Otherwise go to IDLE.
- `o_busy`=1 in START/DATA/STOP.
- `i_data` is sampled only at the accepting edge; later changes do not affect queued bytes.
- Reset asserted mid-frame abandons the frame: the line returns high immediately and queued bytes are lost.

## Timing
- Write latency: `i_wr` accepted at edge N into an empty FIFO with FSM in IDLE → pop at edge N+1 → `o_tx_data` falls after edge N+1, and `o_busy` rises after edge N+1.
- Frame length is 10×CLKS_PER_BIT cycles from the start-bit edge to the end of the stop bit.
- `o_done` is high for exactly 1 cycle, beginning at the edge that ends the stop bit.
- Back-to-back throughput is one byte per 10×CLKS_PER_BIT cycles, with no extra cycles between frames.
- `o_full` updates one edge after the push or pop that causes the change.

## Test plan
1. **Reset.** Hold `i_rst_n`=0 with `i_wr` toggling.
   - Required: `o_tx_data`=1, `o_busy`=0, `o_full`=0, `o_done`=0 throughout.
   - After release, no frame starts.
2. **Single byte, default parameters.** Write 0x5A.
   - Required: line falls 1 cycle after the write edge, then bits 0,0,1,0,1,1,0,1,0,1 each last exactly 10416 cycles.
   - `o_done` pulses once, 104160 cycles after the start-bit edge.
   - Loopback `receiver` reports `o_data`=0x5A with `o_wr`.
3. **Back-to-back, CLKS_PER_BIT=4.** Write 0x6D, 0xE3, 0xC7 on consecutive cycles.
   - Required: three contiguous frames, 120 cycles total, no idle-high gap between stop and start.
   - `o_done` pulses at cycles 40, 80, 120 relative to the first start.
4. **Overflow, FIFO_DEPTH=4.** While frame 0x11 is in DATA, write 0x01..0x05.
   - Required: `o_full`=1 after the 4th write, and 0x05 is dropped.
   - Output is exactly 0x11, 0x01, 0x02, 0x03, 0x04, then the line idles.
5. **Reset mid-frame.** Queue 0xA5 and 0x3C, then assert `i_rst_n`=0 during data bit 3 of 0xA5.
   - Required: `o_tx_data`=1 and `o_busy`=0 within the same cycle, with no clock edge needed.
   - After release, the line stays idle and 0x3C is never sent.
6. **Write at stop end, CLKS_PER_BIT=4.** FIFO empty; write 0x80 on the same edge the stop bit of 0x01 ends.
   - Required: FSM enters IDLE, pops 0x80 on the next edge, and the start bit begins 1 cycle after the stop bit ends.
